// File: rtl/score_display_pkg.sv
// Shared types, seven-segment codes and sizing helpers for the score display path.
package score_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   // Segment order is gfedcba, active-high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic int max_disp(input int nd);
      int r;
      r = 1;
      for (int i = 0; i < nd; i++) begin
         r = r * 10;
      end
      return r - 1;
   endfunction

   // Nibbles needed to hold 2^sw-1 in BCD, returned as a bit width.
   function automatic int bcd_w(input int sw);
      int v;
      int d;
      v = (1 << sw) - 1;
      d = 1;
      for (int i = 0; i < 6; i++) begin
         if (v > 9) begin
            v = v / 10;
            d = d + 1;
         end
      end
      return 4 * d;
   endfunction

endpackage

// File: rtl/score_display_if.sv
// Handshake/data bundle between the score source and score_display_scan.
// Optional hex_mode_i exists only when SCORE_DISPLAY_HEX_MODE_EN is defined.
interface score_display_if #(
   parameter int SCORE_W    = 7,
   parameter int NUM_DIGITS = 2
);
   logic                    load_i;
   logic [SCORE_W-1:0]      value_i;
   logic                    blink_i;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
   logic                    hex_mode_i;
`endif
   logic                    busy_o;
   logic                    done_o;
   logic                    overflow_o;
   logic [4*NUM_DIGITS-1:0] bcd_o;
   logic [6:0]              seg_o;
   logic [NUM_DIGITS-1:0]   dig_en_o;

   modport master (
`ifdef SCORE_DISPLAY_HEX_MODE_EN
      output hex_mode_i,
`endif
      output load_i, value_i, blink_i,
      input  busy_o, done_o, overflow_o, bcd_o, seg_o, dig_en_o
   );

   modport slave (
`ifdef SCORE_DISPLAY_HEX_MODE_EN
      input  hex_mode_i,
`endif
      input  load_i, value_i, blink_i,
      output busy_o, done_o, overflow_o, bcd_o, seg_o, dig_en_o
   );
endinterface

// File: rtl/seg7_lut.sv
// Nibble to seven-segment decode with blank override.
// Hex glyphs A-F decode only when SCORE_DISPLAY_HEX_MODE_EN is defined.
module seg7_lut
   import score_display_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
`endif
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/score_display_scan.sv
// Binary score -> BCD (sequential double-dabble) with saturation, then multiplexed 7-seg scan.
// Optional raw-hex display path enabled by SCORE_DISPLAY_HEX_MODE_EN.
module score_display_scan
   import score_display_pkg::*;
#(
   parameter int SCORE_W    = 7,
   parameter int NUM_DIGITS = 2,
   parameter int SCAN_DIV   = 20,
   parameter int BLINK_DIV  = 50
) (
   input logic             clk,
   input logic             rst,
   score_display_if.slave  bus
);

   localparam int BW     = bcd_w(SCORE_W);
   localparam int SRW    = BW + SCORE_W;
   localparam int DW     = 4 * NUM_DIGITS;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W  = $clog2(SCORE_W + 1);
   localparam int SLOT_W = $clog2(SCAN_DIV + 1);
   localparam int BLK_W  = $clog2(BLINK_DIV + 1);
   localparam logic [31:0] MAX_DISP = 32'(max_disp(NUM_DIGITS));

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_SHIFT  = 2'(ST_SHIFT);
   localparam logic [1:0] S_COMMIT = 2'(ST_COMMIT);

   logic [1:0]         state_q, state_d;
   logic [SRW-1:0]     sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] value_q, value_d;
   logic               pend_v_q, pend_v_d;
   logic [SCORE_W-1:0] pend_val_q, pend_val_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic [DW-1:0]      bcd_q, bcd_d;
   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic               phase_q, phase_d;
   logic [6:0]         seg_q;
   logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
   logic               hex_q, hex_d;
   logic               pend_hex_q, pend_hex_d;
   logic               start_hex_s;
`endif

   logic               start_s;
   logic [SCORE_W-1:0] start_val_s;
   logic [SRW-1:0]     sr_adj_s;
   logic [31:0]        val_ext_s;
   logic [DW-1:0]      commit_bcd_s;
   logic               commit_ovf_s;
   logic               nz_s;
   logic               blank_s;
   logic [3:0]         cur_nib_s;
   logic [6:0]         seg_s;

   // Result selection for the commit cycle: saturated BCD or raw hex nibbles.
   always_comb begin
      val_ext_s = 32'(value_q);
      for (int k = 0; k < SRW; k++) begin
         sr_adj_s[k] = sr_q[k];
      end
      for (int k = 0; k < BW / 4; k++) begin
         if (sr_q[SCORE_W + 4*k +: 4] >= 4'd5) begin
            sr_adj_s[SCORE_W + 4*k +: 4] = sr_q[SCORE_W + 4*k +: 4] + 4'd3;
         end else begin
            sr_adj_s[SCORE_W + 4*k +: 4] = sr_q[SCORE_W + 4*k +: 4];
         end
      end
      commit_ovf_s = (val_ext_s > MAX_DISP);
      if (commit_ovf_s) begin
         commit_bcd_s = {NUM_DIGITS{4'h9}};
      end else begin
         commit_bcd_s = DW'(sr_q[SRW-1:SCORE_W]);
      end
`ifdef SCORE_DISPLAY_HEX_MODE_EN
      if (hex_q) begin
         commit_ovf_s = ((val_ext_s >> DW) != 32'd0);
         commit_bcd_s = DW'(value_q);
      end else begin
         commit_ovf_s = commit_ovf_s;
      end
`endif
   end

   // Conversion FSM with one-entry latest-wins pending slot.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      value_d     = value_q;
      pend_v_d    = pend_v_q;
      pend_val_d  = pend_val_q;
      bcd_d       = bcd_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      start_s     = 1'b0;
      start_val_s = bus.value_i;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
      hex_d       = hex_q;
      pend_hex_d  = pend_hex_q;
      start_hex_s = bus.hex_mode_i;
`endif
      if (bus.load_i && (state_q != S_IDLE)) begin
         pend_v_d   = 1'b1;
         pend_val_d = bus.value_i;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
         pend_hex_d = bus.hex_mode_i;
`endif
      end else begin
         pend_v_d = pend_v_q;
      end
      case (state_q)
         S_IDLE: begin
            start_s = bus.load_i;
         end
         S_SHIFT: begin
            sr_d  = {sr_adj_s[SRW-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SCORE_W - 1)) begin
               state_d = S_COMMIT;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_COMMIT: begin
            bcd_d    = commit_bcd_s;
            ovf_d    = commit_ovf_s;
            done_d   = 1'b1;
            pend_v_d = 1'b0;
            if (bus.load_i) begin
               start_s = 1'b1;
            end else if (pend_v_q) begin
               start_s     = 1'b1;
               start_val_s = pend_val_q;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
               start_hex_s = pend_hex_q;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (start_s) begin
         value_d = start_val_s;
         sr_d    = SRW'(start_val_s);
         cnt_d   = '0;
         state_d = S_SHIFT;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
         hex_d = start_hex_s;
         if (start_hex_s) begin
            state_d = S_COMMIT;
         end else begin
            state_d = S_SHIFT;
         end
`endif
      end else begin
         value_d = value_q;
      end
      busy_d = (state_d == S_SHIFT);
   end

   // Scan slot, digit index, blink phase, leading-zero blanking.
   always_comb begin
      slot_d  = slot_q + SLOT_W'(1);
      idx_d   = idx_q;
      blk_d   = blk_q + BLK_W'(1);
      phase_d = phase_q;
      if (slot_q == SLOT_W'(SCAN_DIV - 1)) begin
         slot_d = '0;
         if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         idx_d = idx_q;
      end
      if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
         blk_d   = '0;
         phase_d = ~phase_q;
      end else begin
         phase_d = phase_q;
      end
      nz_s = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if ((j >= int'(idx_q)) && (bcd_q[4*j +: 4] != 4'd0)) begin
            nz_s = 1'b1;
         end else begin
            nz_s = nz_s;
         end
      end
      blank_s   = ((idx_q != '0) && !nz_s) || (bus.blink_i && !phase_q);
      cur_nib_s = bcd_q[4*int'(idx_q) +: 4];
      dig_en_d  = NUM_DIGITS'(1) << idx_q;
   end

   seg7_lut u_seg7_lut (
      .nib_i   (cur_nib_s),
      .blank_i (blank_s),
      .seg_o   (seg_s)
   );

   // State registers; synchronous reset aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         value_q    <= '0;
         pend_v_q   <= 1'b0;
         pend_val_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         slot_q     <= '0;
         idx_q      <= '0;
         blk_q      <= '0;
         phase_q    <= 1'b0;
         seg_q      <= 7'h00;
         dig_en_q   <= '0;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
         hex_q      <= 1'b0;
         pend_hex_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         value_q    <= value_d;
         pend_v_q   <= pend_v_d;
         pend_val_q <= pend_val_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         bcd_q      <= bcd_d;
         slot_q     <= slot_d;
         idx_q      <= idx_d;
         blk_q      <= blk_d;
         phase_q    <= phase_d;
         seg_q      <= seg_s;
         dig_en_q   <= dig_en_d;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
         hex_q      <= hex_d;
         pend_hex_q <= pend_hex_d;
`endif
      end
   end

   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.overflow_o = ovf_q;
   assign bus.bcd_o      = bcd_q;
   assign bus.seg_o      = seg_q;
   assign bus.dig_en_o   = dig_en_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed self-checking bench for score_display_scan at default parameters.
module tb_score_display_scan;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   score_display_if #(.SCORE_W(7), .NUM_DIGITS(2)) bus ();

   score_display_scan #(
      .SCORE_W    (7),
      .NUM_DIGITS (2),
      .SCAN_DIV   (20),
      .BLINK_DIV  (50)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Load v, check busy length and the done pulse at t+8 with the expected result.
   task automatic convert(input string tag, input int v, input logic [7:0] exp_bcd, input logic exp_ovf);
      int nb;
      bus.load_i  = 1'b1;
      bus.value_i = 7'(v);
      step();
      bus.load_i = 1'b0;
      nb = int'(bus.busy_o);
      for (int i = 1; i <= 7; i++) begin
         step();
         nb += int'(bus.busy_o);
      end
      chk({tag, "_early_done"}, 32'(bus.done_o), 32'd0);
      step();
      chk({tag, "_busy_cycles"}, 32'(nb), 32'd7);
      chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
      chk({tag, "_bcd"}, 32'(bus.bcd_o), 32'(exp_bcd));
      chk({tag, "_ovf"}, 32'(bus.overflow_o), 32'(exp_ovf));
      step();
      chk({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
   endtask

   // Wait for a digit slot to begin, then check its segments and dwell length.
   task automatic chk_digit(input string tag, input logic [1:0] tgt, input logic [6:0] exp_seg);
      int n;
      int hold;
      int seg_bad;
      logic [1:0] prev;
      n    = 0;
      prev = bus.dig_en_o;
      while ((n < 200) && !((bus.dig_en_o == tgt) && (prev != tgt))) begin
         prev = bus.dig_en_o;
         step();
         n++;
      end
      chk({tag, "_seg"}, 32'(bus.seg_o), 32'(exp_seg));
      hold    = 0;
      seg_bad = 0;
      while ((n < 400) && (bus.dig_en_o == tgt)) begin
         if (bus.seg_o != exp_seg) seg_bad++;
         hold++;
         step();
         n++;
      end
      chk({tag, "_hold"}, 32'(hold), 32'd20);
      chk({tag, "_seg_stable"}, 32'(seg_bad), 32'd0);
   endtask

   initial begin
      int dones;
      int seen33;
      int zeros;
      int run;
      int maxrun;
      int de0;
      int changes;
      logic [1:0] prev_en;

      total = 0;
      bad   = 0;
      clk   = 1'b0;
      rst   = 1'b1;
      bus.load_i  = 1'b0;
      bus.value_i = 7'd0;
      bus.blink_i = 1'b0;
`ifdef SCORE_DISPLAY_HEX_MODE_EN
      bus.hex_mode_i = 1'b0;
`endif
      step();
      step();
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
      chk("rst_bcd", 32'(bus.bcd_o), 32'd0);
      chk("rst_seg", 32'(bus.seg_o), 32'd0);
      chk("rst_dig_en", 32'(bus.dig_en_o), 32'd0);
      rst = 1'b0;
      step();
      chk("first_dig_en", 32'(bus.dig_en_o), 32'd1);

      convert("load42", 42, 8'h42, 1'b0);
      chk_digit("d0_42", 2'b01, 7'h5B);
      chk_digit("d1_42", 2'b10, 7'h66);

      convert("load5", 5, 8'h05, 1'b0);
      chk_digit("d1_5", 2'b10, 7'h00);
      chk_digit("d0_5", 2'b01, 7'h6D);

      convert("load127", 127, 8'h99, 1'b1);
      convert("load3", 3, 8'h03, 1'b0);
      convert("load99", 99, 8'h99, 1'b0);
      convert("load100", 100, 8'h99, 1'b1);

      // Back-to-back loads: 33 is overwritten in the pending slot by 17.
      bus.load_i  = 1'b1;
      bus.value_i = 7'd10;
      step();
      dones  = 0;
      seen33 = 0;
      for (int n = 1; n <= 20; n++) begin
         bus.load_i  = (n == 3) || (n == 5);
         bus.value_i = (n == 3) ? 7'd33 : 7'd17;
         step();
         if (bus.bcd_o == 8'h33) seen33 = 1;
         if (bus.done_o) begin
            dones++;
            if (dones == 1) begin
               chk("pend_done1_cycle", 32'(n), 32'd8);
               chk("pend_done1_bcd", 32'(bus.bcd_o), 32'h10);
            end else if (dones == 2) begin
               chk("pend_done2_cycle", 32'(n), 32'd16);
               chk("pend_done2_bcd", 32'(bus.bcd_o), 32'h17);
            end
         end
      end
      bus.load_i = 1'b0;
      chk("pend_done_count", 32'(dones), 32'd2);
      chk("pend_no_33", 32'(seen33), 32'd0);

      convert("load88", 88, 8'h88, 1'b0);
      bus.blink_i = 1'b1;
      zeros   = 0;
      run     = 0;
      maxrun  = 0;
      de0     = 0;
      changes = 0;
      prev_en = bus.dig_en_o;
      for (int i = 0; i < 200; i++) begin
         step();
         if (bus.seg_o == 7'h00) begin
            zeros++;
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
         if (bus.dig_en_o == 2'b00) de0++;
         if (bus.dig_en_o != prev_en) changes++;
         prev_en = bus.dig_en_o;
      end
      bus.blink_i = 1'b0;
      chk("blink_zero_cycles", 32'(zeros), 32'd100);
      chk("blink_max_window", 32'(maxrun), 32'd50);
      chk("blink_dig_en_live", 32'(de0), 32'd0);
      chk("blink_scan_moves", 32'(changes >= 9), 32'd1);
      step();
      chk("blink_off_seg", 32'(bus.seg_o), 32'h7F);

      // Reset four cycles into a conversion.
      bus.load_i  = 1'b1;
      bus.value_i = 7'd55;
      step();
      bus.load_i = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy_o), 32'd0);
      chk("abort_done", 32'(bus.done_o), 32'd0);
      chk("abort_ovf", 32'(bus.overflow_o), 32'd0);
      chk("abort_bcd", 32'(bus.bcd_o), 32'd0);
      chk("abort_seg", 32'(bus.seg_o), 32'd0);
      chk("abort_dig_en", 32'(bus.dig_en_o), 32'd0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.done_o) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_bcd_held", 32'(bus.bcd_o), 32'd0);

      convert("load9", 9, 8'h09, 1'b0);
      chk_digit("d1_9", 2'b10, 7'h00);
      chk_digit("d0_9", 2'b01, 7'h6F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
- Parametrised successor to the two-digit score display path.
- Accepts a binary score of SCORE_W bits and converts it to NUM_DIGITS BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto one seven-segment bus with a one-hot digit enable; adds leading-zero blanking, saturation and blink.
- Sits between score_tracker (dispScore, isGameComplete) and the ss* outputs in top.

Parameters:
- SCORE_W, 7: binary score width, range 1..16.
- NUM_DIGITS, 2: number of displayed decimal digits, range 1..5.
- SCAN_DIV, 20: clk cycles per digit scan slot, must be at least 1.
- BLINK_DIV, 50: clk cycles per blink half-period, must be at least 1.

Ports:
- clk  in  1  system clock (hz100 in top).
- rst  in  1  reset, synchronous, active-high.
- load_i  in  1  single-cycle strobe; capture value_i for conversion.
- value_i  in  SCORE_W  binary score.
- blink_i  in  1  level; blink the whole display while high.
- busy_o  out  1  conversion in progress.
- done_o  out  1  single-cycle pulse; the display register has just been updated.
- overflow_o  out  1  last converted value was greater than 10^NUM_DIGITS-1.
- bcd_o  out  4*NUM_DIGITS  display register; digit 0 is in the least significant nibble.
- seg_o  out  7  segment pattern, gfedcba, active-high.
- dig_en_o  out  NUM_DIGITS  one-hot digit enable, active-high.

Behaviour:
- Reset (synchronous, wins over every other input):
  - FSM goes to IDLE; pending slot cleared.
  - busy_o=0, done_o=0, overflow_o=0, bcd_o=0, seg_o=0, dig_en_o=0.
  - Scan, blink and shift counters are cleared.
  - Reset in the middle of a conversion aborts it; no done_o is produced.
- FSM states IDLE, SHIFT, COMMIT.
  - IDLE: load_i=1 captures value_i into the shift register and moves to SHIFT.
  - SHIFT: runs exactly SCORE_W cycles. Each cycle, every BCD nibble that is at least 5 gets +3, then the combined register shifts left by 1. busy_o=1.
  - COMMIT: lasts one cycle. The display register and overflow_o update together and done_o=1. Then the FSM goes to SHIFT if a load is pending, otherwise to IDLE.
- Latency: load_i at cycle t gives done_o and the new bcd_o at t+SCORE_W+1.
- Internal BCD width is enough for 2^SCORE_W-1.
- Saturation: if the value exceeds 10^NUM_DIGITS-1, the display register is loaded with all 9s and overflow_o=1. Otherwise overflow_o=0.
- load_i while busy: value_i goes into a one-entry pending slot and later loads overwrite it (latest wins). The pending value is converted straight after COMMIT with no IDLE cycle.
- load_i in the COMMIT cycle is treated as pending.
- Scan:
  - The slot counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
  - seg_o and dig_en_o are registered, one cycle after the index.
  - dig_en_o is 0 only during the first cycle after reset.
- Blanking: digit k>0 shows seg_o=0 when digits k..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- Blink:
  - The phase toggles every BLINK_DIV cycles and runs freely.
  - When blink_i=1 and phase=0, seg_o=0; dig_en_o keeps scanning.
  - When blink_i=0, segments are driven normally.
- The display keeps showing the old bcd_o during a conversion; there is no tearing.

Optional Feature:
- Macro SCORE_DISPLAY_HEX_MODE_EN.
- Defined:
  - Adds input port hex_mode_i (1 bit).
  - A load with hex_mode_i=1 skips SHIFT and goes IDLE -> COMMIT. Latency is 1 cycle; done_o is still pulsed.
  - Digits are the raw nibbles of value_i, zero-extended or truncated to NUM_DIGITS nibbles. overflow_o=1 only if dropped bits were nonzero.
  - Blanking is unchanged. Segment codes A-F are added.
- Undefined: the port is absent, only decimal mode exists, and codes A-F are unreachable.

Decomposition:
- Package score_display_pkg holds:
  - The FSM state enum.
  - Seven-segment constants for 0-9, A-F and blank.
  - A function max_disp(NUM_DIGITS) returning 10^NUM_DIGITS-1.
  - A function bcd_w(SCORE_W) for the internal BCD width.
- One sub-module, seg7_lut: combinational 4-bit to 7-bit lookup with a blank input, instantiated once on the scan mux output.

Test Plan:
- Defaults, load 42: busy_o high for 7 cycles, done_o at t+8, bcd_o=0x42. Digit 0 shows seg_o=0x5B and digit 1 shows 0x66, each held for 20 cycles.
- Load 5: bcd_o=0x05; digit 1 shows seg_o=0 (blanked), digit 0 shows 0x6D.
- Load 127 with NUM_DIGITS=2: bcd_o=0x99, overflow_o=1. Then load 3: overflow_o=0, bcd_o=0x03.
- Load 10, then load 33 on cycle t+3 and load 17 on t+5: exactly two done_o pulses, at t+8 (bcd_o=0x10) and t+16 (bcd_o=0x17). The value 33 is never shown.
- blink_i=1 for 200 cycles: seg_o is forced to 0 in alternating 50-cycle windows and dig_en_o keeps rotating.
- rst at t+4 of a conversion: all outputs 0 on the next cycle, no done_o, bcd_o=0. A later load of 9 converts normally.
